// File: rtl/jzjpcc_fetch_control.sv
// ============================================================================
// Module  : jzjpcc_fetch_control
// Brief   : Fetch-stage sequencer. Handles post-reset warm-up, trap/redirect
//           arbitration against hazard stalls and halts, and flush bubbles.
//           Optional perf counters: JZJPCC_FETCH_PERF_COUNTERS_EN
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module jzjpcc_fetch_control #(
    parameter int                PC_MAX_B    = 31,
    parameter int                INIT_CYCLES = 2,
    parameter logic [PC_MAX_B:2] TRAP_VECTOR = '0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                hazard_stall,
    input  logic                redirect_valid,
    input  logic [PC_MAX_B:2]   redirect_target,
    input  logic                trap_valid,
    input  logic                halt_req,
    input  logic                resume,
    output logic                initialize,
    output logic                stall_fetch,
    output logic                pcCTWriteEnable,
    output logic [PC_MAX_B:2]   controlTransferNewPC,
    output logic                flush_fetch,
`ifdef JZJPCC_FETCH_PERF_COUNTERS_EN
    output logic [31:0]         stall_count,
    output logic [31:0]         redirect_count,
`endif
    output logic                halted
);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam int CNT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] c_INIT_LAST =
        CNT_W'((INIT_CYCLES > 0) ? INIT_CYCLES - 1 : 0);
    // With no warm-up the controller comes out of reset already running.
    localparam state_t c_RESET_STATE = (INIT_CYCLES == 0) ? ST_RUN : ST_INIT;

    state_t              r_state,  w_state_nxt;
    logic [CNT_W-1:0]    r_init_cnt, w_init_cnt_nxt;
    logic                r_pend_valid, w_pend_valid_nxt;
    logic                r_pend_trap,  w_pend_trap_nxt;
    logic [PC_MAX_B:2]   r_pend_target, w_pend_target_nxt;
    logic [1:0]          r_flush_cnt;
    logic                w_xfer;
    logic [PC_MAX_B:2]   w_xfer_pc;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state       <= c_RESET_STATE;
            r_init_cnt    <= '0;
            r_pend_valid  <= 1'b0;
            r_pend_trap   <= 1'b0;
            r_pend_target <= '0;
            r_flush_cnt   <= 2'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_init_cnt    <= w_init_cnt_nxt;
            r_pend_valid  <= w_pend_valid_nxt;
            r_pend_trap   <= w_pend_trap_nxt;
            r_pend_target <= w_pend_target_nxt;
            if (w_xfer)
                r_flush_cnt <= 2'd2;
            else if (r_flush_cnt != 2'd0)
                r_flush_cnt <= r_flush_cnt - 2'd1;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_init_cnt_nxt    = r_init_cnt;
        w_pend_valid_nxt  = r_pend_valid;
        w_pend_trap_nxt   = r_pend_trap;
        w_pend_target_nxt = r_pend_target;
        w_xfer            = 1'b0;
        w_xfer_pc         = '0;
        initialize        = 1'b0;
        stall_fetch       = 1'b0;

        case (r_state)
            ST_INIT: begin
                initialize     = 1'b1;
                w_init_cnt_nxt = r_init_cnt + 1'b1;
                if (r_init_cnt == c_INIT_LAST) begin
                    w_state_nxt    = ST_RUN;
                    w_init_cnt_nxt = '0;
                end
                // A buffered trap is never displaced by a later redirect.
                if (trap_valid) begin
                    w_pend_valid_nxt  = 1'b1;
                    w_pend_trap_nxt   = 1'b1;
                    w_pend_target_nxt = TRAP_VECTOR;
                end else if (redirect_valid && !(r_pend_valid && r_pend_trap)) begin
                    w_pend_valid_nxt  = 1'b1;
                    w_pend_trap_nxt   = 1'b0;
                    w_pend_target_nxt = redirect_target;
                end
            end

            ST_RUN: begin
                w_pend_valid_nxt = 1'b0;
                w_pend_trap_nxt  = 1'b0;
                if (trap_valid) begin
                    w_xfer    = 1'b1;
                    w_xfer_pc = TRAP_VECTOR;
                end else if (redirect_valid) begin
                    w_xfer    = 1'b1;
                    w_xfer_pc = redirect_target;
                end else if (r_pend_valid) begin
                    w_xfer    = 1'b1;
                    w_xfer_pc = r_pend_target;
                end
                stall_fetch = hazard_stall && !w_xfer;
                if (halt_req && !w_xfer)
                    w_state_nxt = ST_HALT;
            end

            ST_HALT: begin
                if (trap_valid) begin
                    w_xfer      = 1'b1;
                    w_xfer_pc   = TRAP_VECTOR;
                    w_state_nxt = ST_RUN;
                end else begin
                    stall_fetch = 1'b1;
                    if (resume)
                        w_state_nxt = ST_RUN;
                end
            end

            default: w_state_nxt = c_RESET_STATE;
        endcase
    end

    assign pcCTWriteEnable      = w_xfer;
    assign controlTransferNewPC = w_xfer_pc;
    assign flush_fetch          = (r_flush_cnt != 2'd0);
    assign halted               = (r_state == ST_HALT);

`ifdef JZJPCC_FETCH_PERF_COUNTERS_EN
    logic [31:0] r_stall_count;
    logic [31:0] r_redirect_count;
    logic        w_stall_active;

    assign w_stall_active = stall_fetch && (r_state != ST_INIT);

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_stall_count    <= '0;
            r_redirect_count <= '0;
        end else begin
            if (w_stall_active && (r_stall_count != '1))
                r_stall_count <= r_stall_count + 32'd1;
            if (w_xfer && (r_redirect_count != '1))
                r_redirect_count <= r_redirect_count + 32'd1;
        end
    end

    assign stall_count    = r_stall_count;
    assign redirect_count = r_redirect_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_jzjpcc_fetch_control.sv
// Table-driven bench for jzjpcc_fetch_control (INIT_CYCLES=2, TRAP_VECTOR=0x10).
`default_nettype none

module tb_jzjpcc_fetch_control;

    logic        clock = 1'b0;
    logic        reset;
    logic        hazard_stall, redirect_valid, trap_valid, halt_req, resume;
    logic [31:2] redirect_target;
    logic        initialize, stall_fetch, pcCTWriteEnable, flush_fetch, halted;
    logic [31:2] controlTransferNewPC;
`ifdef JZJPCC_FETCH_PERF_COUNTERS_EN
    logic [31:0] stall_count, redirect_count;
`endif

    always #5 clock = ~clock;

    jzjpcc_fetch_control #(
        .PC_MAX_B    (31),
        .INIT_CYCLES (2),
        .TRAP_VECTOR (30'h10)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .hazard_stall         (hazard_stall),
        .redirect_valid       (redirect_valid),
        .redirect_target      (redirect_target),
        .trap_valid           (trap_valid),
        .halt_req             (halt_req),
        .resume               (resume),
        .initialize           (initialize),
        .stall_fetch          (stall_fetch),
        .pcCTWriteEnable      (pcCTWriteEnable),
        .controlTransferNewPC (controlTransferNewPC),
        .flush_fetch          (flush_fetch),
`ifdef JZJPCC_FETCH_PERF_COUNTERS_EN
        .stall_count          (stall_count),
        .redirect_count       (redirect_count),
`endif
        .halted               (halted)
    );

    // exp packs {initialize, stall_fetch, pcCTWriteEnable, newPC[29:0], flush_fetch, halted}
    typedef struct {
        logic        rst;
        logic        haz;
        logic        rv;
        logic [29:0] rt;
        logic        trap;
        logic        halt;
        logic        res;
        logic        chk;
        logic [34:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic add(input logic rst, input logic haz, input logic rv, input logic [29:0] rt,
                       input logic trap, input logic halt, input logic res, input logic chk,
                       input logic e_init, input logic e_stall, input logic e_we,
                       input logic [29:0] e_pc, input logic e_flush, input logic e_halted);
        vec_t v;
        v.rst = rst; v.haz = haz; v.rv = rv; v.rt = rt; v.trap = trap;
        v.halt = halt; v.res = res; v.chk = chk;
        v.exp = {e_init, e_stall, e_we, e_pc, e_flush, e_halted};
        vecs.push_back(v);
    endtask

    task automatic apply(input vec_t v);
        reset = v.rst; hazard_stall = v.haz; redirect_valid = v.rv;
        redirect_target = v.rt; trap_valid = v.trap; halt_req = v.halt; resume = v.res;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    logic [34:0] act;
    assign act = {initialize, stall_fetch, pcCTWriteEnable, controlTransferNewPC, flush_fetch, halted};

    initial begin
        //   rst haz rv rt     trp hlt res chk | init stl we pc     fl hlt
        add(0, 0, 0, 30'h00, 0, 0, 0, 1,   1, 0, 0, 30'h00, 0, 0); // 0 in reset
        add(1, 0, 0, 30'h00, 0, 0, 0, 1,   1, 0, 0, 30'h00, 0, 0); // 1 INIT c0
        add(1, 0, 0, 30'h00, 0, 0, 0, 1,   1, 0, 0, 30'h00, 0, 0); // 2 INIT c1
        add(1, 0, 0, 30'h00, 0, 0, 0, 1,   0, 0, 0, 30'h00, 0, 0); // 3 RUN idle
        add(1, 1, 0, 30'h00, 0, 0, 0, 1,   0, 1, 0, 30'h00, 0, 0); // 4 hazard
        add(1, 1, 1, 30'h40, 0, 0, 0, 1,   0, 0, 1, 30'h40, 0, 0); // 5 redirect beats hazard
        add(1, 0, 0, 30'h00, 0, 0, 0, 1,   0, 0, 0, 30'h00, 1, 0); // 6 flush 1
        add(1, 0, 1, 30'h50, 0, 0, 0, 1,   0, 0, 1, 30'h50, 1, 0); // 7 flush 2 + reload
        add(1, 0, 0, 30'h00, 0, 0, 0, 1,   0, 0, 0, 30'h00, 1, 0); // 8
        add(1, 0, 1, 30'h80, 1, 0, 0, 1,   0, 0, 1, 30'h10, 1, 0); // 9 trap beats redirect
        add(1, 0, 0, 30'h00, 0, 0, 0, 1,   0, 0, 0, 30'h00, 1, 0); // 10 no 0x80 later
        add(1, 0, 0, 30'h00, 0, 0, 0, 1,   0, 0, 0, 30'h00, 1, 0); // 11
        add(1, 0, 0, 30'h00, 0, 1, 0, 1,   0, 0, 0, 30'h00, 0, 0); // 12 halt_req
        add(1, 0, 1, 30'h44, 0, 0, 0, 1,   0, 1, 0, 30'h00, 0, 1); // 13 HALT ignores redirect
        add(1, 0, 0, 30'h00, 0, 0, 0, 1,   0, 1, 0, 30'h00, 0, 1); // 14
        add(1, 0, 0, 30'h00, 0, 0, 1, 1,   0, 1, 0, 30'h00, 0, 1); // 15 resume
        add(1, 0, 0, 30'h00, 0, 0, 0, 1,   0, 0, 0, 30'h00, 0, 0); // 16 RUN sequential
        add(1, 0, 1, 30'h48, 0, 1, 0, 1,   0, 0, 1, 30'h48, 0, 0); // 17 redirect beats halt
        add(1, 0, 0, 30'h00, 0, 0, 0, 1,   0, 0, 0, 30'h00, 1, 0); // 18 not halted
        add(1, 0, 0, 30'h00, 0, 0, 0, 1,   0, 0, 0, 30'h00, 1, 0); // 19
        add(1, 0, 0, 30'h00, 0, 1, 0, 1,   0, 0, 0, 30'h00, 0, 0); // 20 halt_req
        add(1, 0, 0, 30'h00, 1, 0, 0, 1,   0, 0, 1, 30'h10, 0, 1); // 21 trap leaves HALT
        add(1, 0, 0, 30'h00, 0, 0, 0, 1,   0, 0, 0, 30'h00, 1, 0); // 22 RUN, flushing
        add(0, 0, 0, 30'h00, 0, 0, 0, 0,   0, 0, 0, 30'h00, 0, 0); // 23 reset edge pending
        add(0, 0, 0, 30'h00, 0, 0, 0, 1,   1, 0, 0, 30'h00, 0, 0); // 24 flush discarded
        add(1, 0, 1, 30'h20, 0, 0, 0, 1,   1, 0, 0, 30'h00, 0, 0); // 25 redirect in INIT c0
        add(1, 0, 0, 30'h00, 1, 0, 0, 1,   1, 0, 0, 30'h00, 0, 0); // 26 trap in INIT c1
        add(1, 0, 0, 30'h00, 0, 0, 0, 1,   0, 0, 1, 30'h10, 0, 0); // 27 pending trap applied
        add(1, 0, 0, 30'h00, 0, 0, 0, 1,   0, 0, 0, 30'h00, 1, 0); // 28 pending cleared
        add(1, 0, 0, 30'h00, 0, 0, 0, 1,   0, 0, 0, 30'h00, 1, 0); // 29
        add(1, 0, 0, 30'h00, 0, 0, 0, 1,   0, 0, 0, 30'h00, 0, 0); // 30
        add(0, 0, 0, 30'h00, 0, 0, 0, 0,   0, 0, 0, 30'h00, 0, 0); // 31
        add(0, 0, 0, 30'h00, 0, 0, 0, 1,   1, 0, 0, 30'h00, 0, 0); // 32
        add(1, 0, 0, 30'h00, 1, 0, 0, 1,   1, 0, 0, 30'h00, 0, 0); // 33 trap in INIT c0
        add(1, 0, 1, 30'h30, 0, 0, 0, 1,   1, 0, 0, 30'h00, 0, 0); // 34 redirect can't displace
        add(1, 0, 0, 30'h00, 0, 0, 0, 1,   0, 0, 1, 30'h10, 0, 0); // 35
        add(1, 0, 0, 30'h00, 0, 0, 0, 1,   0, 0, 0, 30'h00, 1, 0); // 36
        add(0, 0, 0, 30'h00, 0, 0, 0, 0,   0, 0, 0, 30'h00, 0, 0); // 37
        add(0, 0, 0, 30'h00, 0, 0, 0, 1,   1, 0, 0, 30'h00, 0, 0); // 38
        add(1, 0, 1, 30'h20, 0, 0, 0, 1,   1, 0, 0, 30'h00, 0, 0); // 39 redirect c0
        add(1, 0, 1, 30'h24, 0, 0, 0, 1,   1, 0, 0, 30'h00, 0, 0); // 40 redirect overwrites
        add(1, 1, 0, 30'h00, 0, 0, 0, 1,   0, 0, 1, 30'h24, 0, 0); // 41 pending beats hazard

        reset = 1'b0; hazard_stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
        trap_valid = 1'b0; halt_req = 1'b0; resume = 1'b0;
        repeat (2) @(negedge clock);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clock);
            apply(vecs[i]);
            #1;
            if (vecs[i].chk)
                check($sformatf("vec%0d", i), 64'(act), 64'(vecs[i].exp));
        end

        // Warm-up length measured directly, bounded so a stuck INIT cannot hang.
        begin
            int n_init;
            n_init = 0;
            @(negedge clock);
            reset = 1'b0; hazard_stall = 1'b0; redirect_valid = 1'b0;
            trap_valid = 1'b0; halt_req = 1'b0; resume = 1'b0;
            repeat (2) @(negedge clock);
            reset = 1'b1;
            for (int i = 0; i < 10; i++) begin
                #1;
                if (!initialize) break;
                n_init++;
                @(negedge clock);
            end
            check("init_cycles", 64'(n_init), 64'd2);
        end

`ifdef JZJPCC_FETCH_PERF_COUNTERS_EN
        hazard_stall = 1'b1;
        repeat (3) @(negedge clock);
        hazard_stall = 1'b0; redirect_valid = 1'b1; redirect_target = 30'h60;
        @(negedge clock);
        redirect_valid = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        check("stall_count", 64'(stall_count), 64'd3);
        check("redirect_count", 64'(redirect_count), 64'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
